// File: rtl/cordic_freq_est.sv
// cordic_freq_est: FM discriminator and boxcar frequency averager fed by a
// vectoring CORDIC. Emits the wrapped sample-to-sample phase difference and
// its mean over 2^AVG_LOG2 differences.
// Optional feature: define CORDIC_FREQ_SQUELCH_EN to reject low-magnitude
// samples (mag_i < MAG_THRESH) and restart the phase reference after them.
module cordic_freq_est #(
    parameter int unsigned          PH_BITS    = 32,
    parameter int unsigned          XY_BITS    = 32,
    parameter int unsigned          AVG_LOG2   = 4,
    parameter logic [XY_BITS-1:0]   MAG_THRESH = XY_BITS'(32'h0010_0000)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ivalid,
    input  logic [PH_BITS-1:0]  phase_i,
    input  logic [XY_BITS-1:0]  mag_i,
    output logic                ovalid,
    output logic [PH_BITS-1:0]  freq_o,
    output logic                avg_valid,
    output logic [PH_BITS-1:0]  avg_o
);

    // A zero-length average still needs a one-bit counter that never advances.
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ACC_W = PH_BITS + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    // StEmpty: no phase reference held; StRun: prev_q is a valid reference.
    typedef enum logic [0:0] {StEmpty, StRun} state_e;

    state_e                    state_q;
    logic [PH_BITS-1:0]        prev_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;

    logic                      accept;
    logic                      reject;
    logic signed [PH_BITS-1:0] diff;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   avg_shift;

`ifdef CORDIC_FREQ_SQUELCH_EN
    // Gate samples whose magnitude is too small for a trustworthy phase.
    always_comb begin
        accept = ivalid && (mag_i >= MAG_THRESH);
        reject = ivalid && (mag_i <  MAG_THRESH);
    end
`else
    logic unused_mag;
    assign unused_mag = ^mag_i;

    // Every strobed sample is used; magnitude is irrelevant.
    always_comb begin
        accept = ivalid;
        reject = 1'b0;
    end
`endif

    // Wrapped phase difference and the running sum including it.
    always_comb begin
        diff      = phase_i - prev_q;
        acc_sum   = acc_q + ACC_W'(diff);
        avg_shift = acc_sum >>> AVG_LOG2;
    end

    // Reference tracking, discriminator output and boxcar averaging.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StEmpty;
            prev_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovalid    <= 1'b0;
            freq_o    <= '0;
            avg_valid <= 1'b0;
            avg_o     <= '0;
        end else begin
            ovalid    <= 1'b0;
            avg_valid <= 1'b0;
            if (accept) begin
                prev_q <= phase_i;
                if (state_q == StEmpty) begin
                    state_q <= StRun;
                end else begin
                    ovalid <= 1'b1;
                    freq_o <= diff;
                    if (cnt_q == CNT_LAST) begin
                        avg_o     <= avg_shift[PH_BITS-1:0];
                        avg_valid <= 1'b1;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end else if (reject) begin
                // Accumulator is kept so the average spans the squelched gap.
                state_q <= StEmpty;
            end
        end
    end

endmodule

// File: tb/tb_cordic_freq_est.sv
// Bench for cordic_freq_est: three instances (AVG_LOG2 = 4, 2, 0) share one
// directed stimulus stream; a behavioural model is compared every cycle and
// literal expectations pin the hand-computed cases.
module tb_cordic_freq_est;

`ifdef CORDIC_FREQ_SQUELCH_EN
    localparam bit SQUELCH = 1'b1;
`else
    localparam bit SQUELCH = 1'b0;
`endif
    localparam logic [31:0] THRESH = 32'h100;

    logic        clock;
    logic        reset;
    logic        ivalid;
    logic [31:0] phase_i;
    logic [31:0] mag_i;

    logic        ov   [3];
    logic [31:0] freq [3];
    logic        av   [3];
    logic [31:0] avg  [3];

    int n_tests;
    int n_fail;
    bit armed;

    cordic_freq_est #(.PH_BITS(32), .XY_BITS(32), .AVG_LOG2(4), .MAG_THRESH(THRESH)) dut4 (
        .clock(clock), .reset(reset), .ivalid(ivalid), .phase_i(phase_i), .mag_i(mag_i),
        .ovalid(ov[0]), .freq_o(freq[0]), .avg_valid(av[0]), .avg_o(avg[0])
    );
    cordic_freq_est #(.PH_BITS(32), .XY_BITS(32), .AVG_LOG2(2), .MAG_THRESH(THRESH)) dut2 (
        .clock(clock), .reset(reset), .ivalid(ivalid), .phase_i(phase_i), .mag_i(mag_i),
        .ovalid(ov[1]), .freq_o(freq[1]), .avg_valid(av[1]), .avg_o(avg[1])
    );
    cordic_freq_est #(.PH_BITS(32), .XY_BITS(32), .AVG_LOG2(0), .MAG_THRESH(THRESH)) dut0 (
        .clock(clock), .reset(reset), .ivalid(ivalid), .phase_i(phase_i), .mag_i(mag_i),
        .ovalid(ov[2]), .freq_o(freq[2]), .avg_valid(av[2]), .avg_o(avg[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lg_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: reference phase, window sum and count per instance.
    bit          m_have [3];
    logic [31:0] m_ref  [3];
    longint      m_sum  [3];
    int          m_n    [3];
    logic [31:0] m_freq [3];
    logic [31:0] m_avg  [3];
    bit          m_ov   [3];
    bit          m_av   [3];

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0;
            m_av[k] = 1'b0;
            if (reset) begin
                m_have[k] = 1'b0;
                m_ref[k]  = '0;
                m_sum[k]  = 0;
                m_n[k]    = 0;
                m_freq[k] = '0;
                m_avg[k]  = '0;
            end else if (ivalid) begin
                if (SQUELCH && mag_i < THRESH) begin
                    m_have[k] = 1'b0;
                end else if (!m_have[k]) begin
                    m_have[k] = 1'b1;
                    m_ref[k]  = phase_i;
                end else begin
                    logic [31:0] d;
                    longint      q;
                    longint      n_len;
                    d         = phase_i - m_ref[k];
                    m_ref[k]  = phase_i;
                    m_freq[k] = d;
                    m_ov[k]   = 1'b1;
                    m_sum[k]  = m_sum[k] + longint'(signed'(d));
                    m_n[k]    = m_n[k] + 1;
                    n_len     = longint'(1) << lg_of(k);
                    if (m_n[k] == int'(n_len)) begin
                        q = m_sum[k] / n_len;
                        if ((m_sum[k] % n_len) != 0 && m_sum[k] < 0) q = q - 1;
                        m_avg[k] = q[31:0];
                        m_av[k]  = 1'b1;
                        m_sum[k] = 0;
                        m_n[k]   = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clock) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ovalid[%0d]", k), {31'b0, ov[k]}, {31'b0, m_ov[k]});
                check($sformatf("freq_o[%0d]", k), freq[k], m_freq[k]);
                check($sformatf("avg_valid[%0d]", k), {31'b0, av[k]}, {31'b0, m_av[k]});
                check($sformatf("avg_o[%0d]", k), avg[k], m_avg[k]);
            end
        end
    end

    // Inputs change on the falling edge and are held for one full cycle.
    task automatic step(input logic v, input logic [31:0] ph, input logic [31:0] mg);
        ivalid  = v;
        phase_i = ph;
        mag_i   = mg;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ivalid = 1'b0;
        @(negedge clock);
        reset  = 1'b0;
    endtask

    task automatic samp(input logic [31:0] ph);
        step(1'b1, ph, 32'h200);
    endtask

    task automatic idle();
        step(1'b0, 32'hDEAD_BEEF, 32'h200);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        armed   = 1'b0;
        reset   = 1'b1;
        ivalid  = 1'b0;
        phase_i = '0;
        mag_i   = '0;
        @(negedge clock);
        do_reset();
        armed = 1'b1;
        check("reset ovalid", {31'b0, ov[0]}, 32'h0);
        check("reset freq_o", freq[0], 32'h0);
        check("reset avg_o", avg[1], 32'h0);

        // Ramp: first sample only loads the reference.
        samp(32'h0000);
        check("ramp first no ovalid", {31'b0, ov[0]}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            samp(32'(i) * 32'h1000);
            check("ramp ovalid", {31'b0, ov[0]}, 32'h1);
            check("ramp freq", freq[0], 32'h1000);
        end
        idle();
        check("ramp hold freq", freq[0], 32'h1000);
        check("ramp pulse drop", {31'b0, ov[0]}, 32'h0);

        // Phase wrap across +-pi in both directions.
        do_reset();
        samp(32'h7FFF_F000);
        samp(32'h8000_1000);
        check("wrap fwd", freq[0], 32'h0000_2000);
        samp(32'h7FFF_F000);
        check("wrap rev", freq[0], 32'hFFFF_E000);

        // Averaging with AVG_LOG2=2: diffs 4,8,12,16 then -1,-2,-1,-2.
        do_reset();
        samp(32'd0);
        samp(32'd4);
        samp(32'd12);
        samp(32'd24);
        check("avg2 not yet", {31'b0, av[1]}, 32'h0);
        samp(32'd40);
        check("avg2 valid", {31'b0, av[1]}, 32'h1);
        check("avg2 with ovalid", {31'b0, ov[1]}, 32'h1);
        check("avg2 value", avg[1], 32'd10);
        samp(32'd39);
        samp(32'd37);
        samp(32'd36);
        samp(32'd34);
        check("avg2 negative floor", avg[1], 32'hFFFF_FFFE);
        check("avg0 tracks freq", avg[2], 32'hFFFF_FFFE);

        // Gapped feed matches back-to-back differences.
        do_reset();
        samp(32'h100);
        for (int g = 0; g < 3; g++) idle();
        samp(32'h300);
        check("gap freq 1", freq[0], 32'h200);
        for (int g = 0; g < 3; g++) idle();
        samp(32'h600);
        check("gap freq 2", freq[0], 32'h300);

        // Reset mid-average discards the partial sum.
        do_reset();
        for (int i = 0; i < 4; i++) samp(32'(i));
        do_reset();
        samp(32'd10);
        check("post reset no output", {31'b0, ov[1]}, 32'h0);
        samp(32'd11);
        samp(32'd12);
        samp(32'd13);
        check("fresh avg pending", {31'b0, av[1]}, 32'h0);
        samp(32'd14);
        check("fresh avg valid", {31'b0, av[1]}, 32'h1);
        check("fresh avg value", avg[1], 32'd1);

        // Reset and a sample in the same cycle: the sample is dropped.
        reset = 1'b1;
        step(1'b1, 32'h5000, 32'h200);
        reset = 1'b0;
        samp(32'h5100);
        check("reset wins", {31'b0, ov[0]}, 32'h0);
        samp(32'h5300);
        check("after reset-win freq", freq[0], 32'h200);

        // Low-magnitude middle sample.
        do_reset();
        samp(32'h00);
        samp(32'h10);
        step(1'b1, 32'h20, 32'h80);
`ifdef CORDIC_FREQ_SQUELCH_EN
        check("squelch rejected", {31'b0, ov[0]}, 32'h0);
        samp(32'h30);
        check("squelch reload", {31'b0, ov[0]}, 32'h0);
        samp(32'h40);
        check("squelch resume", {31'b0, ov[0]}, 32'h1);
        check("squelch resume freq", freq[0], 32'h10);
`else
        check("lowmag accepted", {31'b0, ov[0]}, 32'h1);
        samp(32'h30);
        samp(32'h40);
        check("lowmag freq", freq[0], 32'h10);
`endif

        // Longer deterministic stream exercising the 16-sample average.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ph;
            ph = 32'(i * i) * 32'h0123_4567 + 32'(i) * 32'h89AB_CDEF;
            if (i % 7 == 3) idle();
            samp(ph);
        end
        idle();
        idle();

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
